// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - Wishbone command-bus bundle for the step scheduler
interface step_scheduler_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - absolute-time step event queue with step/dir pulse generator
module step_scheduler #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          counter,
  step_scheduler_if.slave      wb,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 irq_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [3:0] A_QUEUE  = 4'd0;
  localparam logic [3:0] A_NDIR   = 4'd1;
  localparam logic [3:0] A_STATUS = 4'd2;
  localparam logic [3:0] A_PULSE  = 4'd3;
  localparam logic [3:0] A_SETUP  = 4'd4;
  localparam logic [3:0] A_IRQCFG = 4'd5;

  logic [1:0]    state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          late_q, late_d;
  logic          ovf_q, ovf_d;
  logic          next_dir_q, next_dir_d;
  logic [7:0]    pulse_q, pulse_d;
  logic [7:0]    setup_q, setup_d;
  logic [CW-1:0] thresh_q, thresh_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [32:0]   mem_q [DEPTH];

  logic          access, wr_en, rd_en;
  logic          full, empty;
  logic          push_ok, pop;
  logic [32:0]   head;
  logic [31:0]   diff;
  logic          due, late_now;
  logic [7:0]    pulse_eff, setup_eff;
  logic [31:0]   status_w;

  assign access    = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr_en     = access & wb.wb_we_i;
  assign rd_en     = access & ~wb.wb_we_i;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = wr_en & (wb.wb_adr_i == A_QUEUE) & ~full;
  assign head      = mem_q[rd_ptr_q];
  // Signed-by-wrap comparison keeps events correct across counter rollover.
  assign diff      = counter - head[31:0];
  assign due       = ~empty & ~diff[31];
  assign late_now  = (diff > 32'd255);
  assign pulse_eff = (pulse_q == 8'd0) ? 8'd1 : pulse_q;
  assign setup_eff = (setup_q == 8'd0) ? 8'd1 : setup_q;

  always_comb begin
    status_w           = '0;
    status_w[CW-1:0]   = count_q;
    status_w[8]        = empty;
    status_w[9]        = full;
    status_w[10]       = ovf_q;
    status_w[11]       = late_q;
  end

  always_comb begin
    ack_d      = access;
    dat_d      = '0;
    next_dir_d = next_dir_q;
    pulse_d    = pulse_q;
    setup_d    = setup_q;
    thresh_d   = thresh_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    late_d     = late_q;

    if (rd_en) begin
      case (wb.wb_adr_i)
        A_NDIR:   dat_d = {31'd0, next_dir_q};
        A_STATUS: dat_d = status_w;
        A_PULSE:  dat_d = {24'd0, pulse_q};
        A_SETUP:  dat_d = {24'd0, setup_q};
        A_IRQCFG: begin
          dat_d[CW-1:0] = thresh_q;
          dat_d[16]     = irq_en_q;
        end
        default:  dat_d = '0;
      endcase
    end

    if (wr_en) begin
      case (wb.wb_adr_i)
        A_QUEUE:  if (full) ovf_d = 1'b1;
        A_NDIR:   next_dir_d = wb.wb_dat_i[0];
        A_STATUS: begin
          if (wb.wb_dat_i[10]) ovf_d  = 1'b0;
          if (wb.wb_dat_i[11]) late_d = 1'b0;
        end
        A_PULSE:  pulse_d = wb.wb_dat_i[7:0];
        A_SETUP:  setup_d = wb.wb_dat_i[7:0];
        A_IRQCFG: begin
          thresh_d = wb.wb_dat_i[CW-1:0];
          irq_en_d = wb.wb_dat_i[16];
        end
        default:  ;
      endcase
    end

    state_d = state_q;
    timer_d = timer_q;
    step_d  = step_q;
    dir_d   = dir_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (due) begin
          if (head[32] != dir_q) begin
            dir_d   = head[32];
            state_d = ST_SETUP;
            timer_d = setup_eff;
          end else begin
            pop     = 1'b1;
            state_d = ST_HIGH;
            timer_d = pulse_eff;
            step_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (timer_q == 8'd1) begin
          pop     = 1'b1;
          state_d = ST_HIGH;
          timer_d = pulse_eff;
          step_d  = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (timer_q == 8'd1) begin
          step_d  = 1'b0;
          state_d = ST_LOW;
          timer_d = pulse_eff;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_LOW: begin
        if (timer_q == 8'd1) state_d = ST_IDLE;
        else                 timer_d = timer_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A late pop in the same cycle as a STATUS clear keeps the flag set.
    if (pop && late_now) late_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    irq_d    = irq_en_q & (count_q <= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {next_dir_q, wb.wb_dat_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      late_q     <= 1'b0;
      ovf_q      <= 1'b0;
      next_dir_q <= 1'b0;
      pulse_q    <= 8'd2;
      setup_q    <= 8'd2;
      thresh_q   <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      late_q     <= late_d;
      ovf_q      <= ovf_d;
      next_dir_q <= next_dir_d;
      pulse_q    <= pulse_d;
      setup_q    <= setup_d;
      thresh_q   <= thresh_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign step_out    = step_q;
  assign dir_out     = dir_q;
  assign irq_out     = irq_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed bench for step_scheduler
module tb_step_scheduler;

  logic        clk;
  logic        rst;
  logic [31:0] counter;
  logic        load_req;
  logic [31:0] load_val;
  logic        step_out, dir_out, irq_out;
  int          n_checks = 0;
  int          n_errors = 0;

  step_scheduler_if wb_if ();

  step_scheduler #(.DEPTH(4), .CW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .counter  (counter),
    .wb       (wb_if),
    .step_out (step_out),
    .dir_out  (dir_out),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) counter <= load_val;
    else          counter <= counter + 32'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic ack_ok);
    logic a1;
    wb_if.wb_stb_i = 1'b1;
    wb_if.wb_cyc_i = 1'b1;
    wb_if.wb_we_i  = we;
    wb_if.wb_adr_i = adr;
    wb_if.wb_dat_i = wdat;
    @(negedge clk);
    a1   = wb_if.wb_ack_o;
    rdat = wb_if.wb_dat_o;
    wb_if.wb_stb_i = 1'b0;
    wb_if.wb_cyc_i = 1'b0;
    wb_if.wb_we_i  = 1'b0;
    @(negedge clk);
    ack_ok = a1 & ~wb_if.wb_ack_o;
  endtask

  task automatic wb_wr(input logic [3:0] adr, input logic [31:0] wdat);
    logic [31:0] d;
    logic        a;
    wb_xfer(1'b1, adr, wdat, d, a);
  endtask

  task automatic wb_rd(input logic [3:0] adr, output logic [31:0] rdat, output logic ack_ok);
    wb_xfer(1'b0, adr, 32'd0, rdat, ack_ok);
  endtask

  task automatic wait_high(input int which, input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if ((which == 0) ? step_out : dir_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic high_width(output int n);
    n = 0;
    while (step_out && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] t;
    logic [31:0] base;
    logic        ok;
    logic        ack_ok;
    int          n;

    rst = 1'b1;
    load_req = 1'b1;
    load_val = 32'd0;
    wb_if.wb_stb_i = 1'b0;
    wb_if.wb_cyc_i = 1'b0;
    wb_if.wb_we_i  = 1'b0;
    wb_if.wb_adr_i = 4'd0;
    wb_if.wb_dat_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load_req = 1'b0;
    @(negedge clk);

    // Reset state and register defaults
    check_eq("rst_step", step_out, 1'b0);
    check_eq("rst_dir", dir_out, 1'b0);
    check_eq("rst_irq", irq_out, 1'b0);
    check_eq("rst_ack", wb_if.wb_ack_o, 1'b0);
    check_eq("rst_dat", wb_if.wb_dat_o, 32'd0);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("rst_status", rd, 32'h100);
    check_eq("ack_one_cycle", ack_ok, 1'b1);
    wb_rd(4'd3, rd, ack_ok);
    check_eq("rst_pulse", rd, 32'd2);
    wb_rd(4'd4, rd, ack_ok);
    check_eq("rst_setup", rd, 32'd2);
    wb_rd(4'd5, rd, ack_ok);
    check_eq("rst_irqcfg", rd, 32'd0);
    wb_rd(4'd0, rd, ack_ok);
    check_eq("queue_read_zero", rd, 32'd0);
    wb_rd(4'd9, rd, ack_ok);
    check_eq("unmapped_read", rd, 32'd0);
    check_eq("unmapped_ack", ack_ok, 1'b1);

    // Single on-time step, PULSE=3
    wb_wr(4'd3, 32'd3);
    wb_wr(4'd1, 32'd0);
    t = counter + 32'd50;
    wb_wr(4'd0, t);
    wait_high(0, 100, ok);
    check_eq("t2_rise_seen", ok, 1'b1);
    check_eq("t2_rise_counter", counter, t + 32'd1);
    high_width(n);
    check_eq("t2_high_width", n, 32'd3);
    repeat (6) @(negedge clk);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t2_status_empty", rd, 32'h100);

    // Direction change with SETUP=5
    wb_wr(4'd1, 32'd1);
    wb_wr(4'd4, 32'd5);
    t = counter + 32'd20;
    wb_wr(4'd0, t);
    wait_high(1, 100, ok);
    check_eq("t3_dir_seen", ok, 1'b1);
    check_eq("t3_step_low_at_dir", step_out, 1'b0);
    n = 0;
    while (!step_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_setup_cycles", n, 32'd5);
    high_width(n);
    check_eq("t3_high_width", n, 32'd3);
    repeat (6) @(negedge clk);
    check_eq("t3_dir_held", dir_out, 1'b1);

    // Overflow on a full queue, then OVF clear
    for (int i = 0; i < 5; i++) wb_wr(4'd0, counter + 32'd10000);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t4_status_full_ovf", rd, 32'h604);
    wb_wr(4'd2, 32'h400);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t4_status_ovf_clr", rd, 32'h204);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t4_status_after_rst", rd, 32'h100);
    check_eq("t4_dir_after_rst", dir_out, 1'b0);

    // Counter wrap: a time just past rollover must not fire early
    load_req = 1'b1;
    load_val = 32'hFFFF_FFF0;
    @(negedge clk);
    load_req = 1'b0;
    wb_wr(4'd0, 32'h0000_0010);
    repeat (4) @(negedge clk);
    check_eq("t5_no_early_fire", step_out, 1'b0);
    wait_high(0, 100, ok);
    check_eq("t5_wrap_rise_seen", ok, 1'b1);
    check_eq("t5_wrap_rise_counter", counter, 32'h0000_0011);
    repeat (6) @(negedge clk);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t5_no_late", rd, 32'h100);
    t = counter - 32'd1000;
    wb_wr(4'd0, t);
    wait_high(0, 4, ok);
    check_eq("t5_late_immediate", ok, 1'b1);
    repeat (6) @(negedge clk);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t5_late_set", rd, 32'h900);
    wb_wr(4'd2, 32'h800);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t5_late_clr", rd, 32'h100);

    // Low-water IRQ and reset mid-pulse
    base = counter;
    wb_wr(4'd0, base + 32'd40);
    wb_wr(4'd0, base + 32'd60);
    wb_wr(4'd0, base + 32'd80);
    wb_wr(4'd5, 32'h0001_0001);
    @(negedge clk);
    check_eq("t6_irq_three", irq_out, 1'b0);
    wait_high(0, 100, ok);
    check_eq("t6_first_rise", ok, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("t6_irq_two", irq_out, 1'b0);
    wait_high(0, 100, ok);
    check_eq("t6_second_rise", ok, 1'b1);
    check_eq("t6_irq_not_yet", irq_out, 1'b0);
    @(negedge clk);
    check_eq("t6_irq_one", irq_out, 1'b1);
    repeat (3) @(negedge clk);
    wb_wr(4'd0, counter + 32'd5000);
    wait_high(0, 100, ok);
    check_eq("t6_third_rise", ok, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_step_rst", step_out, 1'b0);
    check_eq("t6_irq_rst", irq_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    wb_rd(4'd2, rd, ack_ok);
    check_eq("t6_status_rst", rd, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
